// File: rtl/axi_fsrc_ctrl_scheduler.sv
// axi_fsrc_ctrl_scheduler: walks a {ctrl, dwell} table, issuing one sequencer start per SYSREF-aligned slot
module axi_fsrc_ctrl_scheduler #(
  parameter int CTRL_WIDTH = 40,
  parameter int COUNTER_WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int ACK_TIMEOUT = 4,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sysref,
  input  logic                     wr_en,
  input  logic [ADDR_WIDTH-1:0]    wr_addr,
  input  logic [CTRL_WIDTH-1:0]    wr_ctrl,
  input  logic [COUNTER_WIDTH-1:0] wr_dwell,
  input  logic [ADDR_WIDTH:0]      num_entries,
  input  logic                     loop_en,
  input  logic                     run_start,
  input  logic                     run_stop,
  input  logic                     seq_done,
  output logic                     seq_start,
  output logic [CTRL_WIDTH-1:0]    seq_ctrl_value,
  output logic                     busy,
  output logic [ADDR_WIDTH-1:0]    cur_index,
  output logic                     run_done,
  output logic                     timeout,
  output logic                     cfg_err
);
  localparam logic [1:0] IDLE = 2'd0, DWELL = 2'd1, WAIT_DONE = 2'd2, NEXT = 2'd3;
  localparam logic [3:0] TO_LAST = 4'(ACK_TIMEOUT - 1);
  logic [1:0] state;
  logic [CTRL_WIDTH-1:0] ctrl_mem [DEPTH];
  logic [COUNTER_WIDTH-1:0] dwell_mem [DEPTH];
  logic [COUNTER_WIDTH-1:0] dwell_cnt;
  logic [3:0] to_cnt;
  logic [ADDR_WIDTH-1:0] idx, nxt_idx;
  logic [ADDR_WIDTH:0] num_q;
  logic loop_q, sysref_q, sysref_qq, edge_d, issue, sref_edge, cfg_ok, last;
  assign sref_edge = sysref_q & ~sysref_qq;
  assign busy = state != IDLE;
  assign cur_index = idx;
  assign cfg_ok = num_entries != '0 && num_entries <= (ADDR_WIDTH + 1)'(DEPTH);
  assign last = {1'b0, idx} == num_q - 1'b1;
  assign nxt_idx = last ? '0 : idx + 1'b1;
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      ctrl_mem[wr_addr] <= wr_ctrl;
      dwell_mem[wr_addr] <= wr_dwell;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sysref_q <= 1'b0;
      sysref_qq <= 1'b0;
      edge_d <= 1'b0;
      issue <= 1'b0;
      idx <= '0;
      num_q <= '0;
      loop_q <= 1'b0;
      dwell_cnt <= '0;
      to_cnt <= '0;
      seq_start <= 1'b0;
      seq_ctrl_value <= '0;
      run_done <= 1'b0;
      timeout <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      sysref_q <= sysref;
      sysref_qq <= sysref_q;
      edge_d <= sref_edge;
      issue <= 1'b0;
      seq_start <= 1'b0;
      run_done <= 1'b0;
      timeout <= 1'b0;
      cfg_err <= (wr_en && busy) || (state == IDLE && run_start && !run_stop && !cfg_ok);
      if (run_stop) state <= IDLE;
      else case (state)
        IDLE: if (run_start && cfg_ok) begin
          idx <= '0;
          num_q <= num_entries;
          loop_q <= loop_en;
          dwell_cnt <= dwell_mem[0];
          state <= DWELL;
        end
        DWELL: if (edge_d) begin
          if (dwell_cnt == '0) begin
            issue <= 1'b1;
            to_cnt <= '0;
            state <= WAIT_DONE;
          end else dwell_cnt <= dwell_cnt - 1'b1;
        end
        WAIT_DONE: begin
          if (issue) begin
            seq_start <= 1'b1;
            seq_ctrl_value <= ctrl_mem[idx];
          end
          if (seq_done && !issue && !seq_start) state <= NEXT;
          else if (edge_d) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TO_LAST) begin
              timeout <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: if (last && !loop_q) begin
          run_done <= 1'b1;
          state <= IDLE;
        end else begin
          idx <= nxt_idx;
          dwell_cnt <= dwell_mem[nxt_idx];
          state <= DWELL;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axi_fsrc_ctrl_scheduler.sv
// tb_axi_fsrc_ctrl_scheduler: vector, directed and randomized checks against a pulse-level schedule model
module tb_axi_fsrc_ctrl_scheduler;
  localparam int CW = 40, DW = 4, DEPTH = 8, AW = 3, TO = 4;
  typedef struct {int n; bit exp_cfg; bit exp_busy;} cfg_vec_t;
  logic clk = 1'b0, reset = 1'b1, sysref = 1'b0, wr_en = 1'b0, loop_en = 1'b0;
  logic run_start = 1'b0, run_stop = 1'b0, seq_done = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [CW-1:0] wr_ctrl = '0;
  logic [DW-1:0] wr_dwell = '0;
  logic [AW:0] num_entries = '0;
  logic seq_start, busy, run_done, timeout, cfg_err;
  logic [CW-1:0] seq_ctrl_value;
  logic [AW-1:0] cur_index;
  logic [CW-1:0] m_ctrl [DEPTH];
  int m_dwell [DEPTH];
  int n_chk = 0, n_fail = 0, cyc = 0, ph = 0, pulse_no = 0, rise_cyc = 0;
  bit pulses_on = 0, prev_sr = 0;
  cfg_vec_t vecs [6];
  always #5 clk = ~clk;
  axi_fsrc_ctrl_scheduler #(.CTRL_WIDTH(CW), .COUNTER_WIDTH(DW), .DEPTH(DEPTH), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .sysref(sysref), .wr_en(wr_en), .wr_addr(wr_addr), .wr_ctrl(wr_ctrl),
    .wr_dwell(wr_dwell), .num_entries(num_entries), .loop_en(loop_en), .run_start(run_start),
    .run_stop(run_stop), .seq_done(seq_done), .seq_start(seq_start), .seq_ctrl_value(seq_ctrl_value),
    .busy(busy), .cur_index(cur_index), .run_done(run_done), .timeout(timeout), .cfg_err(cfg_err)
  );
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic tick();
    sysref = pulses_on && ((ph % 16) < 4);
    if (sysref && !prev_sr) begin
      rise_cyc = cyc + 1;
      pulse_no++;
    end
    prev_sr = sysref;
    ph++;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic idle(input int nn);
    pulses_on = 0;
    repeat (nn) tick();
  endtask
  task automatic wr_entry(input int a, input logic [CW-1:0] c, input int d);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_ctrl = c;
    wr_dwell = DW'(d);
    tick();
    wr_en = 1'b0;
    m_ctrl[a] = c;
    m_dwell[a] = d;
  endtask
  task automatic do_run(input int n, input bit lp, input int drop_k, input int late_k, input int stop_k);
    int k = 0, e = 0, exp_p = 0, resp_at = -1, stop_at = -1, to_p = -1, late_p = -1, done_cyc = -1, spur = 0;
    bit fin = 0, stopping = 0;
    logic [CW-1:0] last_ctrl = '0;
    num_entries = (AW + 1)'(n);
    loop_en = lp;
    ph = 9;
    pulse_no = 0;
    pulses_on = 1;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    check("run_busy", busy, 1);
    exp_p = m_dwell[0] + 1;
    for (int c = 0; c < 4000 && !fin; c++) begin
      seq_done = 1'b0;
      run_stop = 1'b0;
      run_start = 1'b0;
      if (stopping) begin
        check("stop_busy", busy, 0);
        check("stop_ctrl_held", seq_ctrl_value, last_ctrl);
        check("stop_no_done", run_done, 0);
        fin = 1;
      end else begin
        if (seq_start) begin
          e = k % n;
          check("issue_ctrl", seq_ctrl_value, m_ctrl[e]);
          check("issue_index", cur_index, e);
          check("issue_pulse", pulse_no, exp_p);
          check("issue_latency", cyc - rise_cyc, 3);
          check("issue_in_range", lp || k < n, 1);
          last_ctrl = m_ctrl[e];
          if (k == drop_k) begin
            seq_done = 1'b1;
            to_p = exp_p + TO;
          end else if (k == late_k) late_p = exp_p + TO;
          else if (k == stop_k) stop_at = cyc + int'($urandom_range(1, 9));
          else resp_at = cyc + int'($urandom_range(1, 9));
          exp_p = (k == late_k ? exp_p + TO : exp_p) + m_dwell[(k + 1) % n] + 1;
          k++;
        end
        if (timeout) begin
          check("timeout_pulse", pulse_no, to_p);
          check("timeout_latency", cyc - rise_cyc, 2);
          check("timeout_idle", busy, 0);
          fin = 1;
        end
        if (run_done) begin
          check("run_done_cycle", cyc, done_cyc + 1);
          check("run_done_count", k, n);
          check("run_done_noloop", lp, 0);
          check("run_done_idle", busy, 0);
          fin = 1;
        end
        if (cyc == resp_at) begin
          seq_done = 1'b1;
          done_cyc = cyc + 1;
        end
        if (late_p >= 0 && pulse_no == late_p && cyc == rise_cyc + 1) begin
          seq_done = 1'b1;
          done_cyc = cyc + 1;
          late_p = -1;
        end
        if (cyc == stop_at) begin
          run_stop = 1'b1;
          run_start = 1'b1;
          stopping = 1;
        end
      end
      if (!fin) tick();
    end
    check("run_finished", fin, 1);
    repeat (24) begin
      tick();
      spur += int'(seq_start | run_done | timeout | busy);
    end
    check("run_quiet_after", spur, 0);
    idle(4);
  endtask
  initial begin
    int w, n, drop, late;
    vecs[0] = '{0, 1, 0};
    vecs[1] = '{DEPTH + 1, 1, 0};
    vecs[2] = '{15, 1, 0};
    vecs[3] = '{1, 0, 1};
    vecs[4] = '{DEPTH, 0, 1};
    vecs[5] = '{3, 0, 1};
    repeat (2) tick();
    check("rst_seq_start", seq_start, 0);
    check("rst_ctrl", seq_ctrl_value, 0);
    check("rst_busy", busy, 0);
    check("rst_index", cur_index, 0);
    check("rst_run_done", run_done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_cfg_err", cfg_err, 0);
    reset = 1'b0;
    idle(2);
    foreach (vecs[i]) begin
      num_entries = (AW + 1)'(vecs[i].n);
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
      check("cfg_err", cfg_err, vecs[i].exp_cfg);
      check("cfg_busy", busy, vecs[i].exp_busy);
      run_stop = 1'b1;
      tick();
      run_stop = 1'b0;
      check("cfg_err_pulse", cfg_err, 0);
      check("cfg_stop_idle", busy, 0);
    end
    wr_entry(0, 40'hA5, 2);
    do_run(1, 0, -1, -1, -1);
    wr_entry(0, 40'h1, 0);
    wr_entry(1, 40'h2, 1);
    wr_entry(2, 40'h3, 0);
    do_run(3, 0, -1, -1, -1);
    wr_entry(1, 40'h2, 0);
    do_run(2, 1, -1, -1, 5);
    do_run(1, 0, 0, -1, -1);
    do_run(2, 0, -1, 0, -1);
    num_entries = 1;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    wr_en = 1'b1;
    wr_addr = 0;
    wr_ctrl = 40'hFF;
    wr_dwell = 5;
    tick();
    wr_en = 1'b0;
    check("busy_wr_cfg_err", cfg_err, 1);
    run_stop = 1'b1;
    tick();
    run_stop = 1'b0;
    check("busy_wr_stop", busy, 0);
    do_run(1, 0, -1, -1, -1);
    num_entries = 2;
    loop_en = 1'b0;
    ph = 9;
    pulse_no = 0;
    pulses_on = 1;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    w = 0;
    while (!seq_start && w < 200) begin
      tick();
      w++;
    end
    check("reset_seq_seen", seq_start, 1);
    tick();
    tick();
    check("reset_pre_busy", busy, 1);
    reset = 1'b1;
    tick();
    check("mid_rst_seq_start", seq_start, 0);
    check("mid_rst_ctrl", seq_ctrl_value, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_index", cur_index, 0);
    check("mid_rst_run_done", run_done, 0);
    check("mid_rst_timeout", timeout, 0);
    check("mid_rst_cfg_err", cfg_err, 0);
    reset = 1'b0;
    idle(4);
    do_run(2, 0, -1, -1, -1);
    repeat (8) begin
      for (int a = 0; a < DEPTH; a++) wr_entry(a, CW'({$urandom(), $urandom()}), int'($urandom_range(0, 3)));
      n = int'($urandom_range(1, DEPTH));
      drop = int'($urandom_range(0, 2 * n));
      late = int'($urandom_range(0, 2 * n));
      if (late == drop) late = -1;
      do_run(n, 0, drop, late, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_fsrc_ctrl_scheduler.md
Name: axi_fsrc_ctrl_scheduler

Overview:
Table-driven scheduler that feeds the FSRC sequencer's control-update path. It holds a small table of {ctrl word, dwell} entries and steps through them, one per SYSREF-aligned slot. For each entry it issues one start pulse with the new ctrl value, then waits for the sequencer's completion handshake. It sits between the regmap and the sequencer's start/next-ctrl inputs and supports automated multi-step rate-change sequences, including looping.

Parameters:
CTRL_WIDTH, 40, width of each ctrl word.
COUNTER_WIDTH, 4, width of the per-entry dwell count, in SYSREF edges.
DEPTH, 8, number of table entries; power of 2, minimum 2.
ACK_TIMEOUT, 4, number of SYSREF edges allowed in WAIT_DONE before abort; range 1..15.
(localparam ADDR_WIDTH = $clog2(DEPTH))

Ports:
clk  in  1  core clock; all logic is in this domain.
reset  in  1  synchronous, active-high reset.
sysref  in  1  SYSREF level, already in the clk domain.
wr_en  in  1  table write strobe.
wr_addr  in  ADDR_WIDTH  table write index.
wr_ctrl  in  CTRL_WIDTH  ctrl word to write.
wr_dwell  in  COUNTER_WIDTH  dwell value to write.
num_entries  in  ADDR_WIDTH+1  number of active entries, 1..DEPTH.
loop_en  in  1  after the last entry, wrap to entry 0.
run_start  in  1  start pulse.
run_stop  in  1  abort pulse.
seq_done  in  1  sequencer completion strobe.
seq_start  out  1  one-cycle start pulse to the sequencer.
seq_ctrl_value  out  CTRL_WIDTH  ctrl word for the sequencer; held stable between pulses.
busy  out  1  high whenever state is not IDLE.
cur_index  out  ADDR_WIDTH  index of the entry in progress.
run_done  out  1  one-cycle pulse on normal completion.
timeout  out  1  one-cycle pulse on handshake timeout.
cfg_err  out  1  one-cycle pulse on an illegal request.

Behaviour:
Reset:
- state=IDLE.
- All outputs 0; cur_index=0; internal counters 0; sysref pipeline 0.
- Table RAM is not reset.

SYSREF edge detection:
- Two-stage pipeline sysref_q, sysref_qq.
- sref_edge = sysref_q & ~sysref_qq.

Table writes:
- Accepted when wr_en=1 and busy=0; entry is written on the same clock edge.
- wr_en while busy=1: write dropped and cfg_err pulses.

States IDLE, DWELL, WAIT_DONE, NEXT:
- IDLE:
  - run_start with 1<=num_entries<=DEPTH: idx<=0, dwell_cnt<=table[0].dwell, go to DWELL.
  - run_start with num_entries==0 or num_entries>DEPTH: cfg_err pulse, stay in IDLE.
  - num_entries and loop_en are sampled at run_start and held for the whole run.
- DWELL, on sref_edge:
  - dwell_cnt==0: in the next cycle seq_start=1 for exactly one cycle, seq_ctrl_value<=table[idx].ctrl in that same cycle, to_cnt<=0, go to WAIT_DONE.
  - dwell_cnt!=0: decrement dwell_cnt.
  - Dwell 0 issues on the first edge after entering DWELL.
  - seq_start rises exactly 3 clk edges after the first edge that samples sysref high.
- WAIT_DONE:
  - seq_done=1: go to NEXT. seq_done sampled in the same cycle as seq_start is ignored.
  - Each sref_edge increments to_cnt.
  - If to_cnt reaches ACK_TIMEOUT with no seq_done: timeout pulse, go to IDLE.
  - If seq_done and the timeout-reaching edge occur in the same cycle, seq_done wins.
- NEXT (exactly 1 cycle):
  - idx==num_entries-1 with loop_en=1: idx<=0.
  - idx==num_entries-1 with loop_en=0: run_done pulse, go to IDLE.
  - Otherwise: idx<=idx+1.
  - When continuing, load dwell_cnt from the new entry and go to DWELL.
  - A sref_edge in the NEXT cycle is not counted.
- run_stop:
  - In any state, go to IDLE on the next edge; no run_done.
  - Has priority over run_start and over seq_start issue in the same cycle.
  - seq_ctrl_value keeps its last value.
- cur_index = idx.
- seq_ctrl_value changes only with a seq_start pulse.

Test Plan:
- Single entry: write entry0 ctrl=40'hA5, dwell=2; num_entries=1; run_start; sysref pulses every 16 clk → seq_start on the 3rd sysref edge, exactly 3 clk after sysref first sampled high, with seq_ctrl_value=40'hA5; seq_done 5 clk later → run_done after 1 cycle, busy=0.
- Three entries (ctrl 1/2/3, dwell 0/1/0), loop_en=0 → seq_start on sysref edges 1, 3 and 4 with ctrl 1, 2, 3; cur_index steps 0→1→2; one run_done.
- loop_en=1, two entries, dwell 0 → ctrl sequence 1,2,1,2,… and no run_done; run_stop → busy=0 next cycle and seq_ctrl_value keeps its last value.
- Timeout: ACK_TIMEOUT=4, seq_done held low → timeout pulse on the 4th sysref edge after seq_start, then IDLE; seq_done coincident with the 4th edge → NEXT, no timeout.
- Errors: run_start with num_entries=0 → cfg_err, busy stays 0; wr_en while busy → cfg_err and table unchanged (readback via a later run).
- Reset asserted during WAIT_DONE → all outputs 0 next cycle; table contents preserved, so a rerun reproduces the same ctrl values.
